// File: rtl/sap1e_pkg.sv
// rtl/sap1e_pkg.sv - shared state encoding and requester indices for the RAM arbiter
package sap1e_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic REQ_LOADER = 1'b0;
  localparam logic REQ_CPU    = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker with a maskable requester 1
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       mask_r1,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] w_elig;

  assign w_elig      = {req[1] & ~mask_r1, req[0]};
  assign grant_valid = |w_elig;
  // On a tie the requester not served last wins; otherwise the sole eligible one.
  assign grant_idx   = (&w_elig) ? ~last : w_elig[1];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - serializes loader and CPU accesses to the single-port RAM in 3-cycle transactions
module ram_arbiter
  import sap1e_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  prog_mode,
  input  logic                  r0_req,
  input  logic                  r1_req,
  input  logic                  r0_we,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r0_ack,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_data_in_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  state_e                r_state;
  state_e                w_next;
  logic                  r_owner;
  logic                  r_we;
  logic                  r_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_r0_rdata;
  logic [DATA_WIDTH-1:0] r_r1_rdata;
  logic                  r_r0_ack;
  logic                  r_r1_ack;
  logic                  w_grant_valid;
  logic                  w_grant_idx;
  logic                  w_grant;
  logic                  w_capture;

  rr_pick2 u_pick (
    .req         ({r1_req, r0_req}),
    .mask_r1     (prog_mode),
    .last        (r_last),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_grant        = 1'b0;
    w_capture      = 1'b0;
    ram_data_in_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_grant = 1'b1;
          w_next  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // Write enable is gated by reset so a reset landing in SERVE cannot corrupt RAM.
        ram_data_in_en = r_we & ~reset;
        w_capture      = ~r_we;
        w_next         = ST_ACK;
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner    <= REQ_LOADER;
      r_we       <= 1'b0;
      r_last     <= REQ_CPU;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_r0_rdata <= '0;
      r_r1_rdata <= '0;
      r_r0_ack   <= 1'b0;
      r_r1_ack   <= 1'b0;
    end else begin
      r_r0_ack <= 1'b0;
      r_r1_ack <= 1'b0;
      if (w_grant) begin
        r_owner <= w_grant_idx;
        r_last  <= w_grant_idx;
        r_we    <= w_grant_idx ? r1_we    : r0_we;
        r_addr  <= w_grant_idx ? r1_addr  : r0_addr;
        r_wdata <= w_grant_idx ? r1_wdata : r0_wdata;
      end
      if (r_state == ST_SERVE) begin
        r_r0_ack <= (r_owner == REQ_LOADER);
        r_r1_ack <= (r_owner == REQ_CPU);
      end
      if (w_capture) begin
        if (r_owner == REQ_LOADER) r_r0_rdata <= ram_data_out;
        else                       r_r1_rdata <= ram_data_out;
      end
    end
  end

  // The capture registers feed the RAM pins directly, so they hold outside SERVE.
  assign ram_addr    = r_addr;
  assign ram_data_in = r_wdata;
  assign r0_ack      = r_r0_ack;
  assign r1_ack      = r_r1_ack;
  assign r0_rdata    = r_r0_rdata;
  assign r1_rdata    = r_r1_rdata;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port request/acknowledge arbiter that shares the single-port program/data RAM between the loader (requester 0, front-panel/serial program entry) and the CPU fetch/execute path (requester 1). It sits between both requesters and the RAM's `addr` / `data_in` / `data_in_en` / `data_out` pins and serializes every access into a fixed three-cycle transaction. A `prog_mode` input locks the RAM to the loader while a program is being entered.

## Interface
- `DATA_WIDTH`, default 8, RAM word width.
- `ADDR_WIDTH`, default 4, RAM address width (16 words).

- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `prog_mode` in 1: 1 = only requester 0 eligible.
- `r0_req`, `r1_req` in 1: access request; held high until the matching ack.
- `r0_we`, `r1_we` in 1: 1 = write, 0 = read; stable while req is high.
- `r0_addr`, `r1_addr` in ADDR_WIDTH: word address; stable while req is high.
- `r0_wdata`, `r1_wdata` in DATA_WIDTH: write data; stable while req is high.
- `r0_ack`, `r1_ack` out 1: one-cycle completion pulse.
- `r0_rdata`, `r1_rdata` out DATA_WIDTH: registered read result, per requester.
- `ram_addr` out ADDR_WIDTH: to RAM `addr`.
- `ram_data_in` out DATA_WIDTH: to RAM `data_in`.
- `ram_data_in_en` out 1: to RAM `data_in_en`.
- `ram_data_out` in DATA_WIDTH: from RAM `data_out` (combinational read).

## Operation
- States:
  - IDLE: arbitrate.
  - SERVE: drive the RAM.
  - ACK: pulse the ack.
- IDLE:
  - If an eligible req is present, latch the owner, we, addr and wdata into `owner_q`/`we_q`/`addr_q`/`wdata_q`, then go to SERVE.
  - Otherwise stay in IDLE.
- Eligibility:
  - `r0_req` is always eligible.
  - `r1_req` is eligible only when `prog_mode`=0.
- Tie (both eligible): grant the requester not granted last (`last_q`).
  - `last_q` updates on each grant.
  - `last_q` resets to 1, so the first tie goes to r0.
- SERVE:
  - `ram_addr`=`addr_q`, `ram_data_in`=`wdata_q`, `ram_data_in_en`=`we_q & ~reset`.
  - On a read, `ram_data_out` is captured into the owner's rdata register at the end of the cycle.
  - Always go to ACK.
- ACK:
  - The owner's ack is high for exactly this cycle.
  - No arbitration happens in this cycle; always go to IDLE.
  - A requester that keeps req high after ack starts a new transaction in the following IDLE cycle.
- rdata:
  - A requester's rdata changes only on that requester's reads.
  - Writes and the other requester's accesses leave it unchanged.
- `ram_addr` and `ram_data_in` hold their last value outside SERVE. `ram_data_in_en` is high only in SERVE.
- A `prog_mode` change mid-transaction does not affect the transaction in flight; it affects only the next arbitration.

## Timing
- Request sampled in IDLE (cycle 0) → RAM access in cycle 1 → ack in cycle 2 → next grant possible in cycle 3.
- Throughput: one access per 3 cycles. Latency from req to ack: 2 cycles, when the arbiter is IDLE and the requester wins.
- The RAM write commits on the rising edge at the end of SERVE. Read data is valid in rdata in the ACK cycle and holds afterwards.
- Reset values:
  - state IDLE, `last_q`=1.
  - both acks 0, both rdata 0.
  - `ram_addr` 0, `ram_data_in` 0, `ram_data_in_en` 0.
- Reset in any state:
  - Next state is IDLE and no ack is issued.
  - Reset in SERVE suppresses the write (`data_in_en` gated) and does not update rdata.
- Requests present during reset are ignored; arbitration starts in the first cycle after reset deasserts.
- Address wrap-around is not applicable: the full 2^ADDR_WIDTH address space is legal.

## Structure
- Shared package `sap1e_pkg`:
  - state encoding (IDLE, SERVE, ACK, 2 bits).
  - requester indices `REQ_LOADER`=0, `REQ_CPU`=1.
- One sub-module, `rr_pick2`: combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `mask_r1`, `last`.
  - Outputs: `grant_valid`, `grant_idx`.
- FSM, capture registers and rdata registers live in `ram_arbiter`.

## Test plan
- Preload mem[4]=8'h3C. After reset, r1 reads addr 4 → `r1_ack` high exactly 2 cycles after `r1_req`, `r1_rdata`=8'h3C, `ram_data_in_en` never high.
- r0 writes addr 4'hF, data 8'hA5 → `ram_data_in_en` high exactly one cycle with `ram_addr`=F and `ram_data_in`=A5. A subsequent r1 read of F returns A5, and `r0_rdata` stays 0.
- Both reqs high from the first cycle after reset and held → acks strictly alternate r0, r1, r0, r1, each 3 cycles apart.
- `prog_mode`=1 with both reqs held → only r0 is acked and `r1_ack` stays 0. Drop `prog_mode` → r1 is acked at the next arbitration.
- r0 write of 8'h77 to addr 2 (mem[2]=8'h11), with reset asserted during SERVE → mem[2] stays 8'h11, no ack, state IDLE, all outputs at reset values.
- r1 reads addr 1 (8'h5A), then r1 writes addr 1 with 8'h00 → `r1_rdata` still 8'h5A after the write ack.
